key_step_debounce: RTL and testbench
====================================

Name: key_step_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the up/down digit counter driving HEX0.
- Takes the raw, bouncy active-low push button KEY[0] and the raw direction switch SW[0].
- Emits one clean single-cycle step pulse per debounced press, plus a synchronized count-up flag.
- The counter advances on step instead of using the button as its clock.

Parameters:
- STABLE_CYCLES, 16: consecutive synchronized cycles a new button level must hold before it is accepted; legal range 2..1023.
- CNT_W, 10: debounce/repeat counter width; must satisfy 2^CNT_W > max(STABLE_CYCLES, REPEAT_CYCLES).
- REPEAT_CYCLES, 64: auto-repeat period in cycles; used only when AUTO_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock; all flops on its rising edge.
- reset  input  1  asynchronous, active-low reset: 0 resets immediately, release is synchronous to clk.
- key_n  input  1  raw push button, active-low (0 = pressed), asynchronous to clk, may bounce.
- sw_dir  input  1  raw direction switch, asynchronous; 0 = count up, 1 = count down.
- step  output  1  one-cycle pulse per accepted press (and per repeat when enabled).
- up  output  1  synchronized direction: 1 = count up (equals ~sw_dir after synchronization).
- pressed  output  1  debounced button level: 1 while the button is accepted as held.

Behaviour:
- Synchronizers: two-flop chain on key_n (key_s) and on sw_dir (dir_s).
  - key flops reset to 1 (released); dir flops reset to 0.
  - up = ~dir_s, registered; so up reflects a sw_dir change exactly 3 edges later.
- Reset values: step=0, pressed=0, up=1, state=IDLE, cnt=0.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE: key_s==0 -> PRESS_WAIT, cnt<=0; otherwise stay.
- PRESS_WAIT:
  - key_s==1 -> IDLE, cnt<=0 (bounce rejected, no step).
  - key_s==0 and cnt==STABLE_CYCLES-1 -> HELD, step<=1, pressed<=1.
  - key_s==0 otherwise -> cnt<=cnt+1.
- HELD: key_s==1 -> RELEASE_WAIT, cnt<=0; otherwise stay, pressed stays 1.
- RELEASE_WAIT:
  - key_s==0 -> HELD, cnt<=0, no new step.
  - key_s==1 and cnt==STABLE_CYCLES-1 -> IDLE, pressed<=0.
  - otherwise cnt<=cnt+1.
- step is registered and high for exactly one cycle; it defaults to 0 every cycle it is not explicitly set.
- Latency: if key_n is sampled low at edge E and stays low, step is high in the cycle after edge E+2+STABLE_CYCLES.
  - pressed rises in the same cycle as step.
- Release latency: pressed falls in the cycle after edge R+2+STABLE_CYCLES, where R is the first edge sampling key_n high.
- No step is issued on release, and none while in RELEASE_WAIT or IDLE.
- Bounce shorter than STABLE_CYCLES synchronized cycles never produces a step and never drops pressed.
- cnt never exceeds STABLE_CYCLES-1 and never wraps.
- Reset asserted mid-operation: all state and outputs return to reset values immediately.
  - A step in progress is cut off.
  - A button still held at release of reset needs the full press sequence again (IDLE first).
- up is independent of the FSM; direction changes are never masked by button activity.

Optional Feature:
- Macro: KEY_STEP_AUTO_REPEAT_EN.
- When defined:
  - A second counter rpt runs while in HELD and clears on entering HELD.
  - When rpt==REPEAT_CYCLES-1, step pulses for one cycle and rpt<=0.
  - A held button therefore emits a step every REPEAT_CYCLES cycles after the initial step.
  - Leaving HELD (to RELEASE_WAIT) clears rpt; returning from RELEASE_WAIT to HELD restarts rpt at 0.
- When undefined: no rpt logic exists; exactly one step per accepted press regardless of hold time.

Test Plan (STABLE_CYCLES=4, REPEAT_CYCLES=8, 10 ns clk):
- Reset low 2 cycles, then high with key_n=1, sw_dir=0 -> step=0, pressed=0, up=1 for 20 cycles.
- key_n=0 at edge E, held 30 cycles -> step=1 only in the cycle after edge E+6; pressed=1 from then on.
  - Without the macro: exactly one step total.
  - With the macro: further steps 8 cycles apart.
- key_n toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> no step, pressed stays 0.
- Held press, then key_n pulses high for 2 cycles -> pressed stays 1, no extra step.
  - Then key_n=1 held -> pressed falls in the cycle after edge R+6.
- sw_dir 0->1 at edge D -> up=0 from the cycle after edge D+2; no step generated.
- Reset asserted 2 cycles after key_n=0 (mid PRESS_WAIT), released with key_n still 0 -> outputs 0 during reset.
  - step fires in the cycle after the 7th edge following reset release.

Source files
------------

// File: rtl/key_step_debounce_if.sv
// Button/direction bundle between the raw board inputs and the debouncer.
// master: button source and step consumer; slave: the debouncer.
interface key_step_debounce_if;
    logic key_n;
    logic sw_dir;
    logic step;
    logic up;
    logic pressed;

    modport master (
        output key_n,
        output sw_dir,
        input  step,
        input  up,
        input  pressed
    );

    modport slave (
        input  key_n,
        input  sw_dir,
        output step,
        output up,
        output pressed
    );
endinterface

// File: rtl/key_step_debounce.sv
// Debounces KEY[0] into one-cycle step pulses and synchronizes SW[0] into up.
// Optional auto-repeat while held: define KEY_STEP_AUTO_REPEAT_EN.
module key_step_debounce #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 10,
    parameter int REPEAT_CYCLES = 64
) (
    input logic               clk,
    input logic               reset,
    key_step_debounce_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Reject parameter sets where the counters could not reach their terminal value.
    generate
        if (STABLE_CYCLES < 2 || STABLE_CYCLES > 1023 || (1 << CNT_W) <= STABLE_CYCLES
            || (1 << CNT_W) <= REPEAT_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("key_step_debounce: illegal STABLE_CYCLES/REPEAT_CYCLES/CNT_W combination");
        end
    endgenerate

    logic [1:0]       key_sync_reg;
    logic [1:0]       dir_sync_reg;
    logic             up_reg;
    logic             key_s;
    logic             dir_s;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             step_reg, step_next;
    logic             pressed_reg, pressed_next;

    assign key_s = key_sync_reg[1];
    assign dir_s = dir_sync_reg[1];

    // Key chain idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_sync_reg <= 2'b11;
            dir_sync_reg <= 2'b00;
            up_reg       <= 1'b1;
        end else begin
            key_sync_reg <= {key_sync_reg[0], bus.key_n};
            dir_sync_reg <= {dir_sync_reg[0], bus.sw_dir};
            up_reg       <= ~dir_s;
        end
    end

`ifdef KEY_STEP_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rpt_reg, rpt_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            step_reg    <= 1'b0;
            pressed_reg <= 1'b0;
`ifdef KEY_STEP_AUTO_REPEAT_EN
            rpt_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            step_reg    <= step_next;
            pressed_reg <= pressed_next;
`ifdef KEY_STEP_AUTO_REPEAT_EN
            rpt_reg     <= rpt_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        step_next    = 1'b0;
        pressed_next = pressed_reg;
`ifdef KEY_STEP_AUTO_REPEAT_EN
        rpt_next     = rpt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (!key_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next   = HELD;
                    step_next    = 1'b1;
                    pressed_next = 1'b1;
`ifdef KEY_STEP_AUTO_REPEAT_EN
                    rpt_next     = '0;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
`ifdef KEY_STEP_AUTO_REPEAT_EN
                    rpt_next   = '0;
                end else if (rpt_reg == REPEAT_LAST) begin
                    step_next = 1'b1;
                    rpt_next  = '0;
                end else begin
                    rpt_next = rpt_reg + 1'b1;
`endif
                end
            end
            RELEASE_WAIT: begin
                // A key that drops back low is the same press: no new step.
                if (!key_s) begin
                    state_next = HELD;
                    cnt_next   = '0;
`ifdef KEY_STEP_AUTO_REPEAT_EN
                    rpt_next   = '0;
`endif
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next   = IDLE;
                    pressed_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.step    = step_reg;
    assign bus.pressed = pressed_reg;
    assign bus.up      = up_reg;

endmodule

// File: tb/tb_key_step_debounce.sv
// Directed bench for key_step_debounce with STABLE_CYCLES=4, REPEAT_CYCLES=8.
// Honours KEY_STEP_AUTO_REPEAT_EN when the bundle is built with it.
module tb_key_step_debounce;

`ifdef KEY_STEP_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    key_step_debounce_if bus ();

    key_step_debounce #(
        .STABLE_CYCLES(4),
        .CNT_W(10),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        bus.key_n  = 1'b1;
        bus.sw_dir = 1'b0;
        tick();
        tick();
        total++;
        if (bus.step !== 1'b0 || bus.pressed !== 1'b0 || bus.up !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold: step=%b pressed=%b up=%b want 0 0 1", bus.step, bus.pressed, bus.up);
        end
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            total++;
            if (bus.step !== 1'b0 || bus.pressed !== 1'b0 || bus.up !== 1'b1) begin
                bad++;
                $display("FAIL reset_idle[%0d]: step=%b pressed=%b up=%b want 0 0 1", i, bus.step, bus.pressed, bus.up);
            end
        end
        $display("test_reset done");
    endtask

    // Held long enough for several repeats; release edge avoids a repeat slot.
    task automatic test_press_release;
        logic exp_step;
        logic exp_pressed;
        int   nsteps;
        nsteps    = 0;
        bus.key_n = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp_step    = (i == 7) || (AUTO && i > 7 && ((i - 7) % 8) == 0);
            exp_pressed = (i >= 7);
            if (bus.step === 1'b1) nsteps++;
            total++;
            if (bus.step !== exp_step || bus.pressed !== exp_pressed) begin
                bad++;
                $display("FAIL press[%0d]: step=%b pressed=%b want %b %b", i, bus.step, bus.pressed, exp_step, exp_pressed);
            end
        end
        total++;
        if (nsteps != (AUTO ? 4 : 1)) begin
            bad++;
            $display("FAIL press_step_count: got %0d want %0d", nsteps, AUTO ? 4 : 1);
        end
        bus.key_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_pressed = (i < 7);
            total++;
            if (bus.step !== 1'b0 || bus.pressed !== exp_pressed) begin
                bad++;
                $display("FAIL release[%0d]: step=%b pressed=%b want 0 %b", i, bus.step, bus.pressed, exp_pressed);
            end
        end
        $display("test_press_release done, steps seen=%0d", nsteps);
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 20; i++) begin
            bus.key_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            total++;
            if (bus.step !== 1'b0 || bus.pressed !== 1'b0) begin
                bad++;
                $display("FAIL bounce[%0d]: step=%b pressed=%b want 0 0", i, bus.step, bus.pressed);
            end
        end
        bus.key_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (bus.step !== 1'b0 || bus.pressed !== 1'b0) begin
                bad++;
                $display("FAIL bounce_settle[%0d]: step=%b pressed=%b want 0 0", i, bus.step, bus.pressed);
            end
        end
        $display("test_bounce done");
    endtask

    // Press, 2-cycle release glitch, hold again, then a real release.
    task automatic test_held_glitch;
        logic exp_step;
        logic exp_pressed;
        for (int i = 1; i <= 18; i++) begin
            bus.key_n   = (i == 11 || i == 12) ? 1'b1 : 1'b0;
            tick();
            exp_step    = (i == 7);
            exp_pressed = (i >= 7);
            total++;
            if (bus.step !== exp_step || bus.pressed !== exp_pressed) begin
                bad++;
                $display("FAIL glitch[%0d]: step=%b pressed=%b want %b %b", i, bus.step, bus.pressed, exp_step, exp_pressed);
            end
        end
        bus.key_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_pressed = (i < 7);
            total++;
            if (bus.step !== 1'b0 || bus.pressed !== exp_pressed) begin
                bad++;
                $display("FAIL glitch_release[%0d]: step=%b pressed=%b want 0 %b", i, bus.step, bus.pressed, exp_pressed);
            end
        end
        $display("test_held_glitch done");
    endtask

    task automatic test_direction;
        logic exp_up;
        bus.sw_dir = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_up = (i < 3);
            total++;
            if (bus.up !== exp_up || bus.step !== 1'b0) begin
                bad++;
                $display("FAIL dir_down[%0d]: up=%b step=%b want %b 0", i, bus.up, bus.step, exp_up);
            end
        end
        bus.sw_dir = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_up = (i >= 3);
            total++;
            if (bus.up !== exp_up || bus.step !== 1'b0) begin
                bad++;
                $display("FAIL dir_up[%0d]: up=%b step=%b want %b 0", i, bus.up, bus.step, exp_up);
            end
        end
        $display("test_direction done");
    endtask

    task automatic test_reset_mid;
        logic exp_step;
        logic exp_pressed;
        bus.key_n = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (bus.step !== 1'b0 || bus.pressed !== 1'b0 || bus.up !== 1'b1) begin
            bad++;
            $display("FAIL midreset_async: step=%b pressed=%b up=%b want 0 0 1", bus.step, bus.pressed, bus.up);
        end
        @(negedge clk);
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_step    = (i == 7);
            exp_pressed = (i >= 7);
            total++;
            if (bus.step !== exp_step || bus.pressed !== exp_pressed) begin
                bad++;
                $display("FAIL midreset_repress[%0d]: step=%b pressed=%b want %b %b", i, bus.step, bus.pressed, exp_step, exp_pressed);
            end
        end
        // Reset again, then cut the next step off while it is high.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        tick();
        total++;
        if (bus.step !== 1'b1) begin
            bad++;
            $display("FAIL cutoff_pre: step=%b want 1", bus.step);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.step !== 1'b0 || bus.pressed !== 1'b0) begin
            bad++;
            $display("FAIL cutoff: step=%b pressed=%b want 0 0", bus.step, bus.pressed);
        end
        @(negedge clk);
        bus.key_n = 1'b1;
        reset     = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (bus.step !== 1'b0 || bus.pressed !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle[%0d]: step=%b pressed=%b want 0 0", i, bus.step, bus.pressed);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_press_release();
        test_bounce();
        test_held_glitch();
        test_direction();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
